// File: rtl/decode_pkg.sv
// Shared decode types, funct encoding and instruction field-offset helpers.
// DECODE_ILLEGAL_EN: when defined, reserved functs are flagged illegal and write nothing.
package decode_pkg;

  typedef enum logic [31:0] {
    F_ALU0  = 32'd0,
    F_ALU1  = 32'd1,
    F_ALU2  = 32'd2,
    F_ALU3  = 32'd3,
    F_ALU4  = 32'd4,
    F_ALU5  = 32'd5,
    F_ALU6  = 32'd6,
    F_LOAD  = 32'd7,
    F_STORE = 32'd8
  } funct_e;

  typedef struct packed {
    logic bsel;
    logic wbsel;
    logic we_rf;
    logic we_mem;
    logic illegal;
  } decode_ctrl_t;

  localparam int ITYPE_BIT = 0;
  localparam int RS_LO     = 1;

  function automatic int rd_lo(input int rw);
    return rw + 1;
  endfunction

  function automatic int funct_lo(input int rw);
    return 2*rw + 1;
  endfunction

  function automatic int rt_lo(input int rw, input int fw);
    return 2*rw + fw + 1;
  endfunction

  function automatic int rimm_lo(input int rw, input int fw);
    return 3*rw + fw + 1;
  endfunction

  function automatic int imm_w(input int iw, input int rw, input int fw);
    return iw - 1 - 2*rw - fw;
  endfunction

  // Reserved functs either trap (illegal, no writes) or fall back to a plain ALU op.
  function automatic decode_ctrl_t decode_funct(input logic [31:0] funct, input logic itype);
    decode_ctrl_t c;
    c = '0;
    c.bsel = itype;
    if (funct <= F_ALU6) begin
      c.we_rf = 1'b1;
    end else if (funct == F_LOAD) begin
      c.we_rf = 1'b1;
      c.wbsel = 1'b1;
    end else if (funct == F_STORE) begin
      c.we_mem = 1'b1;
    end else begin
`ifdef DECODE_ILLEGAL_EN
      c.illegal = 1'b1;
`else
      c.we_rf = 1'b1;
`endif
    end
    return c;
  endfunction

endpackage

// File: rtl/decode_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared by writeback or flush.
// Lookups see the same-cycle writeback already removed so a retiring register never stalls.
module decode_scoreboard #(
  parameter int RW = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          set_en,
  input  logic [RW-1:0] set_idx,
  input  logic          wb_valid,
  input  logic [RW-1:0] wb_rd,
  input  logic [RW-1:0] rs,
  input  logic [RW-1:0] rt,
  input  logic [RW-1:0] rd,
  output logic          rs_busy,
  output logic          rt_busy,
  output logic          rd_busy
);
  import decode_pkg::*;

  localparam int NREG = 2**RW;

  logic [NREG-1:0] pend;
  logic [NREG-1:0] pend_eff;
  logic [NREG-1:0] clr_mask;
  logic [NREG-1:0] set_mask;

  always_comb begin
    clr_mask = '0;
    set_mask = '0;
    if (wb_valid) clr_mask[wb_rd] = 1'b1;
    if (set_en) set_mask[set_idx] = 1'b1;
    pend_eff = pend & ~clr_mask;
  end

  assign rs_busy = pend_eff[rs];
  assign rt_busy = pend_eff[rt];
  assign rd_busy = pend_eff[rd];

  // Set is OR-ed after the clear so a new writer of a retiring register stays pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= '0;
    end else if (flush) begin
      pend <= '0;
    end else begin
      pend <= pend_eff | set_mask;
    end
  end

endmodule

// File: rtl/instr_decode_stage.sv
// Registered instruction decode stage with valid/ready handshake and RAW/WAW scoreboard stall.
// DECODE_ILLEGAL_EN (see decode_pkg) selects trapping of reserved functs.
module instr_decode_stage
  import decode_pkg::*;
#(
  parameter int IW = 32,
  parameter int RW = 6,
  parameter int FW = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [IW-1:0]           in_instr,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_itype,
  output logic [RW-1:0]           out_rs,
  output logic [RW-1:0]           out_rt,
  output logic [RW-1:0]           out_rd,
  output logic [FW-1:0]           out_aluop,
  output logic [IW-1-2*RW-FW-1:0] out_imm,
  output logic                    out_bsel,
  output logic                    out_wbsel,
  output logic                    out_we_rf,
  output logic                    out_we_mem,
  output logic                    out_illegal,
  input  logic                    wb_valid,
  input  logic [RW-1:0]           wb_rd,
  input  logic                    flush
);

  localparam int RD_LO   = rd_lo(RW);
  localparam int FUNC_LO = funct_lo(RW);
  localparam int RT_LO   = rt_lo(RW, FW);
  localparam int RIMM_LO = rimm_lo(RW, FW);
  localparam int IMMW    = imm_w(IW, RW, FW);

  generate
    if (IW < 1 + 3*RW + FW) begin : g_width_check
      $error("instr_decode_stage: IW too small for 1+3*RW+FW field layout");
    end
  endgenerate

  logic             itype;
  logic [RW-1:0]    rs;
  logic [RW-1:0]    rt;
  logic [RW-1:0]    rd;
  logic [FW-1:0]    funct;
  logic [IMMW-1:0]  imm;
  decode_ctrl_t     ctrl;
  logic             rs_busy;
  logic             rt_busy;
  logic             rd_busy;
  logic             hazard;
  logic             issue;

  // R-type immediates are the bits above rt; I-type uses everything above funct.
  always_comb begin
    itype = in_instr[ITYPE_BIT];
    rs    = in_instr[RS_LO +: RW];
    rd    = in_instr[RD_LO +: RW];
    funct = in_instr[FUNC_LO +: FW];
    rt    = itype ? '0 : in_instr[RT_LO +: RW];
    imm   = itype ? IMMW'(in_instr >> RT_LO) : IMMW'(in_instr >> RIMM_LO);
    ctrl  = decode_funct(32'(funct), itype);
  end

  decode_scoreboard #(.RW(RW)) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .set_en   (issue & ctrl.we_rf),
    .set_idx  (rd),
    .wb_valid (wb_valid),
    .wb_rd    (wb_rd),
    .rs       (rs),
    .rt       (rt),
    .rd       (rd),
    .rs_busy  (rs_busy),
    .rt_busy  (rt_busy),
    .rd_busy  (rd_busy)
  );

  assign hazard   = rs_busy | (~itype & rt_busy) | (ctrl.we_rf & rd_busy);
  assign in_ready = (~out_valid | out_ready) & ~hazard & ~flush;
  assign issue    = in_valid & in_ready;

  // Flush only drops validity; the held fields are don't-care until the next issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_itype   <= 1'b0;
      out_rs      <= '0;
      out_rt      <= '0;
      out_rd      <= '0;
      out_aluop   <= '0;
      out_imm     <= '0;
      out_bsel    <= 1'b0;
      out_wbsel   <= 1'b0;
      out_we_rf   <= 1'b0;
      out_we_mem  <= 1'b0;
      out_illegal <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (issue) begin
      out_valid   <= 1'b1;
      out_itype   <= itype;
      out_rs      <= rs;
      out_rt      <= rt;
      out_rd      <= rd;
      out_aluop   <= funct;
      out_imm     <= imm;
      out_bsel    <= ctrl.bsel;
      out_wbsel   <= ctrl.wbsel;
      out_we_rf   <= ctrl.we_rf;
      out_we_mem  <= ctrl.we_mem;
      out_illegal <= ctrl.illegal;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_decode_stage.sv
// Bench for instr_decode_stage: directed corner sequences, a decode table and a randomized
// run against a spec-level reference model. Honours DECODE_ILLEGAL_EN like the design.
module tb_instr_decode_stage;

  localparam int IW = 32;
  localparam int RW = 6;
  localparam int FW = 4;
  localparam int IMMW = IW - 1 - 2*RW - FW;
`ifdef DECODE_ILLEGAL_EN
  localparam bit ILL_EN = 1'b1;
`else
  localparam bit ILL_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid, in_ready, out_valid, out_ready;
  logic [IW-1:0]   in_instr;
  logic            out_itype, out_bsel, out_wbsel, out_we_rf, out_we_mem, out_illegal;
  logic [RW-1:0]   out_rs, out_rt, out_rd, wb_rd;
  logic [FW-1:0]   out_aluop;
  logic [IMMW-1:0] out_imm;
  logic            wb_valid, flush;

  always #5 clk = ~clk;

  instr_decode_stage #(.IW(IW), .RW(RW), .FW(FW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_itype(out_itype), .out_rs(out_rs),
    .out_rt(out_rt), .out_rd(out_rd), .out_aluop(out_aluop), .out_imm(out_imm),
    .out_bsel(out_bsel), .out_wbsel(out_wbsel), .out_we_rf(out_we_rf), .out_we_mem(out_we_mem),
    .out_illegal(out_illegal), .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush)
  );

  typedef struct {
    logic        itype;
    logic [5:0]  rs, rt, rd;
    logic [3:0]  aluop;
    logic [14:0] imm;
    logic        bsel, wbsel, we_rf, we_mem, illegal;
  } bundle_t;

  typedef struct {
    logic [31:0] instr;
    bundle_t     exp;
  } vec_t;

  int checks = 0;
  int errors = 0;

  bit [63:0] pend_m;
  logic      exp_valid;
  bundle_t   exp_b;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk_r(int unsigned rs, int unsigned rt, int unsigned rd,
                                       int unsigned f, int unsigned imm);
    return (imm << 23) | (rt << 17) | (f << 13) | (rd << 7) | (rs << 1);
  endfunction

  function automatic logic [31:0] mk_i(int unsigned rs, int unsigned rd, int unsigned f,
                                       int unsigned imm);
    return (imm << 17) | (f << 13) | (rd << 7) | (rs << 1) | 32'd1;
  endfunction

  function automatic bundle_t bnd(logic it, int unsigned rs, int unsigned rt, int unsigned rd,
                                  int unsigned op, int unsigned imm, logic wbs, logic wrf,
                                  logic wmem, logic ill);
    bundle_t b;
    b.itype = it; b.rs = 6'(rs); b.rt = 6'(rt); b.rd = 6'(rd); b.aluop = 4'(op);
    b.imm = 15'(imm); b.bsel = it; b.wbsel = wbs; b.we_rf = wrf; b.we_mem = wmem; b.illegal = ill;
    return b;
  endfunction

  // Reference decode straight from the field layout, using division/modulo on the word.
  function automatic bundle_t ref_decode(logic [31:0] ins);
    bundle_t d;
    int unsigned f;
    d.itype = ins[0];
    d.rs = 6'((ins / 2) % 64);
    d.rd = 6'((ins / 128) % 64);
    f = (ins / 8192) % 16;
    d.aluop = 4'(f);
    if (d.itype) begin
      d.rt = '0;
      d.imm = 15'(ins / 131072);
    end else begin
      d.rt = 6'((ins / 131072) % 64);
      d.imm = 15'(ins / 8388608);
    end
    d.bsel = d.itype;
    d.wbsel = (f == 7);
    d.we_mem = (f == 8);
    d.illegal = (f > 8) && ILL_EN;
    d.we_rf = (f <= 7) || ((f > 8) && !ILL_EN);
    return d;
  endfunction

  task automatic model_reset();
    pend_m = '0;
    exp_valid = 1'b0;
    exp_b = bnd(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic model_step(input string name);
    bundle_t   d;
    bit [63:0] eff;
    bit        hz, rdy;
    d = ref_decode(in_instr);
    eff = pend_m;
    if (wb_valid) eff[wb_rd] = 1'b0;
    hz = eff[d.rs] || (!d.itype && eff[d.rt]) || (d.we_rf && eff[d.rd]);
    rdy = (!exp_valid || out_ready) && !hz && !flush;
    chk({name, "_in_ready"}, in_ready, rdy);
    if (flush) begin
      pend_m = '0;
      exp_valid = 1'b0;
    end else begin
      pend_m = eff;
      if (in_valid && rdy) begin
        exp_valid = 1'b1;
        exp_b = d;
        if (d.we_rf) pend_m[d.rd] = 1'b1;
      end else if (out_ready) begin
        exp_valid = 1'b0;
      end
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic ordy,
                               input logic wbv, input logic [5:0] wbr, input logic fl);
    in_valid = v; in_instr = ins; out_ready = ordy;
    wb_valid = wbv; wb_rd = wbr; flush = fl;
    #1;
  endtask

  task automatic checkOutput(input string name);
    chk({name, "_out_valid"}, out_valid, exp_valid);
    if (exp_valid) begin
      chk({name, "_itype"}, out_itype, exp_b.itype);
      chk({name, "_rs"}, out_rs, exp_b.rs);
      chk({name, "_rt"}, out_rt, exp_b.rt);
      chk({name, "_rd"}, out_rd, exp_b.rd);
      chk({name, "_aluop"}, out_aluop, exp_b.aluop);
      chk({name, "_imm"}, out_imm, exp_b.imm);
      chk({name, "_bsel"}, out_bsel, exp_b.bsel);
      chk({name, "_wbsel"}, out_wbsel, exp_b.wbsel);
      chk({name, "_we_rf"}, out_we_rf, exp_b.we_rf);
      chk({name, "_we_mem"}, out_we_mem, exp_b.we_mem);
      chk({name, "_illegal"}, out_illegal, exp_b.illegal);
    end
  endtask

  task automatic cycle(input string name);
    model_step(name);
    @(posedge clk);
    #1;
    checkOutput(name);
  endtask

  task automatic reset_check(input string name);
    chk({name, "_valid"}, out_valid, 0);
    chk({name, "_fields"}, {out_itype, out_rs, out_rt, out_rd, out_aluop}, 0);
    chk({name, "_imm"}, out_imm, 0);
    chk({name, "_ctrl"}, {out_bsel, out_wbsel, out_we_rf, out_we_mem, out_illegal}, 0);
  endtask

  vec_t vecs[8];

  initial begin
    logic [31:0] ins;
    logic [5:0]  wr;
    int unsigned start;

    vecs[0] = '{mk_r(3, 4, 5, 2, 0),         bnd(0, 3, 4, 5, 2, 0, 0, 1, 0, 0)};
    vecs[1] = '{mk_i(1, 2, 0, 'h7fff),       bnd(1, 1, 0, 2, 0, 'h7fff, 0, 1, 0, 0)};
    vecs[2] = '{mk_r(10, 11, 12, 7, 'h1ab),  bnd(0, 10, 11, 12, 7, 'h1ab, 1, 1, 0, 0)};
    vecs[3] = '{mk_i(7, 9, 8, 'h1234),       bnd(1, 7, 0, 9, 8, 'h1234, 0, 0, 1, 0)};
    vecs[4] = '{mk_r(20, 21, 22, 12, 'h0f0), bnd(0, 20, 21, 22, 12, 'h0f0, 0, !ILL_EN, 0, ILL_EN)};
    vecs[5] = '{mk_i(63, 63, 15, 'h4000),    bnd(1, 63, 0, 63, 15, 'h4000, 0, !ILL_EN, 0, ILL_EN)};
    vecs[6] = '{mk_r(0, 63, 0, 6, 'h1ff),    bnd(0, 0, 63, 0, 6, 'h1ff, 0, 1, 0, 0)};
    vecs[7] = '{mk_i(33, 40, 9, 'h0001),     bnd(1, 33, 0, 40, 9, 1, 0, !ILL_EN, 0, ILL_EN)};

    model_reset();
    in_valid = 0; in_instr = 0; out_ready = 0; wb_valid = 0; wb_rd = 0; flush = 0;
    repeat (2) @(posedge clk);
    #1;
    reset_check("reset");
    rst_n = 1'b1;

    // 1: R-type issues with one cycle latency and marks rd=5 pending
    applyStimulus(1, mk_r(3, 4, 5, 2, 0), 1, 0, 0, 0);
    chk("t1_ready", in_ready, 1);
    cycle("t1");
    chk("t1_valid", out_valid, 1);
    chk("t1_aluop", out_aluop, 2);
    chk("t1_we_rf", out_we_rf, 1);
    chk("t1_bsel", out_bsel, 0);

    // 2: RAW on rs=5 stalls, same-cycle writeback bypasses
    applyStimulus(1, mk_i(5, 6, 0, 'h42), 1, 0, 0, 0);
    chk("t2_stall", in_ready, 0);
    cycle("t2_stall");
    applyStimulus(1, mk_i(5, 6, 0, 'h42), 1, 1, 5, 0);
    chk("t2_bypass", in_ready, 1);
    cycle("t2_issue");
    chk("t2_rs", out_rs, 5);
    chk("t2_imm", out_imm, 'h42);

    // 3: output backpressure holds the bundle
    applyStimulus(1, mk_r(1, 2, 8, 3, 'h55), 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      chk("t3_blocked", in_ready, 0);
      cycle("t3_hold");
      chk("t3_stable_rs", out_rs, 5);
    end
    applyStimulus(1, mk_r(1, 2, 8, 3, 'h55), 1, 0, 0, 0);
    chk("t3_release", in_ready, 1);
    cycle("t3_issue");
    chk("t3_rd", out_rd, 8);

    // 4: LOAD rd=7 then STORE rs=7 waits for writeback of 7
    applyStimulus(1, mk_i(1, 7, 7, 0), 1, 0, 0, 0);
    cycle("t4_load");
    chk("t4_load_wbsel", out_wbsel, 1);
    applyStimulus(1, mk_i(7, 0, 8, 'h10), 1, 0, 0, 0);
    chk("t4_stall_a", in_ready, 0);
    cycle("t4_stall_a");
    chk("t4_stall_b", in_ready, 0);
    cycle("t4_stall_b");
    applyStimulus(1, mk_i(7, 0, 8, 'h10), 1, 1, 7, 0);
    chk("t4_wb_ready", in_ready, 1);
    cycle("t4_store");
    chk("t4_we_mem", out_we_mem, 1);
    chk("t4_we_rf", out_we_rf, 0);

    // 5: reserved funct 12
    applyStimulus(1, mk_r(2, 3, 9, 12, 0), 1, 0, 0, 0);
    cycle("t5_res");
    chk("t5_illegal", out_illegal, ILL_EN);
    chk("t5_we_rf", out_we_rf, !ILL_EN);
    applyStimulus(1, mk_i(9, 10, 0, 0), 1, 0, 0, 0);
    chk("t5_pend9", in_ready, ILL_EN);
    cycle("t5_next");
    applyStimulus(0, 0, 1, 0, 0, 1);
    cycle("t5_flush");

    // 6: flush with a held bundle and pending rd=5, then async reset mid-stall
    applyStimulus(1, mk_r(3, 4, 5, 2, 0), 0, 0, 0, 0);
    cycle("t6_issue");
    applyStimulus(1, mk_i(5, 11, 0, 0), 0, 0, 0, 1);
    chk("t6_flush_ready", in_ready, 0);
    cycle("t6_flush");
    chk("t6_flush_valid", out_valid, 0);
    applyStimulus(1, mk_i(5, 11, 0, 0), 1, 0, 0, 0);
    chk("t6_pend_cleared", in_ready, 1);
    cycle("t6_after");
    applyStimulus(1, mk_i(11, 12, 0, 0), 1, 0, 0, 0);
    chk("t6_stall", in_ready, 0);
    cycle("t6_stall");
    #2 rst_n = 1'b0;
    #1 reset_check("t6_reset");
    model_reset();
    in_valid = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    applyStimulus(0, 0, 1, 0, 0, 0);
    cycle("t6_idle");
    chk("t6_no_emit", out_valid, 0);
    applyStimulus(1, mk_i(11, 12, 0, 0), 1, 0, 0, 0);
    chk("t6_sb_cleared", in_ready, 1);
    cycle("t6_fresh");

    // Decode table, each entry issued on a freshly flushed scoreboard
    foreach (vecs[i]) begin
      applyStimulus(0, 0, 1, 0, 0, 1);
      cycle("tbl_flush");
      applyStimulus(1, vecs[i].instr, 1, 0, 0, 0);
      cycle("tbl");
      chk("tbl_valid", out_valid, 1);
      chk("tbl_fields", {out_itype, out_rs, out_rt, out_rd, out_aluop},
          {vecs[i].exp.itype, vecs[i].exp.rs, vecs[i].exp.rt, vecs[i].exp.rd, vecs[i].exp.aluop});
      chk("tbl_imm", out_imm, vecs[i].exp.imm);
      chk("tbl_ctrl", {out_bsel, out_wbsel, out_we_rf, out_we_mem, out_illegal},
          {vecs[i].exp.bsel, vecs[i].exp.wbsel, vecs[i].exp.we_rf, vecs[i].exp.we_mem,
           vecs[i].exp.illegal});
    end

    // Randomized traffic with writebacks mostly aimed at pending registers
    for (int n = 0; n < 3000; n++) begin
      ins = $urandom;
      wr = 6'($urandom_range(0, 63));
      if (pend_m != 0 && $urandom_range(0, 9) < 8) begin
        start = $urandom_range(0, 63);
        for (int j = 0; j < 64; j++) begin
          if (pend_m[(start + j) % 64]) begin
            wr = 6'((start + j) % 64);
            break;
          end
        end
      end
      applyStimulus($urandom_range(0, 9) < 7, ins, $urandom_range(0, 9) < 7,
                    $urandom_range(0, 1) == 1, wr, $urandom_range(0, 49) == 0);
      cycle("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
